// File: rtl/cal_pkg.sv
// Shared calendar types: weekday FSM states, weekday codes and Gregorian month-length helpers.
// Leap rule yy%4==0 is exact for the 2000-2099 window held by the 0..99 year register.
package cal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SUM,
    RED56,
    RED7,
    DONE
  } cal_state_t;

  localparam logic [2:0] DOW_SAT = 3'd0;
  localparam logic [2:0] DOW_SUN = 3'd1;
  localparam logic [2:0] DOW_MON = 3'd2;
  localparam logic [2:0] DOW_TUE = 3'd3;
  localparam logic [2:0] DOW_WED = 3'd4;
  localparam logic [2:0] DOW_THU = 3'd5;
  localparam logic [2:0] DOW_FRI = 3'd6;

  function automatic logic is_leap(input logic [7:0] yy);
    return (yy[1:0] == 2'b00);
  endfunction

  // Returns 0 for an out-of-range month so any day value fails validation.
  function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic leap);
    case (month)
      8'd1, 8'd3, 8'd5, 8'd7, 8'd8, 8'd10, 8'd12: return 8'd31;
      8'd4, 8'd6, 8'd9, 8'd11:                    return 8'd30;
      8'd2:                                       return leap ? 8'd29 : 8'd28;
      default:                                    return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/cal_dow_engine.sv
// Zeller weekday engine: one summing cycle, then iterative mod-7 reduction by 56 and 7.
// Latency start-to-done <= 16 cycles; start is ignored while busy, inputs must hold until done.
module cal_dow_engine
  import cal_pkg::*;
#(
  parameter int unsigned CENTURY = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] yy,
  input  logic [7:0] month,
  input  logic [7:0] day,
  output logic       busy,
  output logic       done,
  output logic [2:0] dow
);

  cal_state_t state, state_nx;
  logic [8:0] acc, acc_nx;
  logic [4:0] m;
  logic [7:0] k;
  logic [7:0] j;
  logic [9:0] sum;

  // Jan/Feb count as months 13/14 of the previous year; 2000 borrows into the prior century.
  always_comb begin
    m = month[4:0];
    k = yy;
    j = 8'(CENTURY);
    if (month <= 8'd2) begin
      m = month[4:0] + 5'd12;
      if (yy == 8'd0) begin
        k = 8'd99;
        j = 8'(CENTURY - 1);
      end else begin
        k = yy - 8'd1;
      end
    end
    sum = {2'b00, day}
        + ((10'd13 * ({5'b0, m} + 10'd1)) / 10'd5)
        + {2'b00, k}
        + {4'b0000, k[7:2]}
        + {4'b0000, j[7:2]}
        + (10'd5 * {2'b00, j});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    case (state)
      IDLE: if (start) state_nx = SUM;
      SUM: begin
        acc_nx   = sum[8:0];
        state_nx = RED56;
      end
      RED56: begin
        if (acc >= 9'd56) acc_nx = acc - 9'd56;
        else              state_nx = RED7;
      end
      RED7: begin
        if (acc >= 9'd7) acc_nx = acc - 9'd7;
        else             state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign dow  = acc[2:0];

endmodule

// File: rtl/calendar_date_ctrl.sv
// Calendar date owner: daily advance, validated set-date, weekday via cal_dow_engine; CAL_WEEK_TICK_EN adds week_tick.
// Tick/set take effect in one cycle when idle; weekday recompute <= 16 cycles after start.
// Ticks arriving while busy are held in a 1-deep pending flag; set_req waits while busy or pending.
module calendar_date_ctrl
  import cal_pkg::*;
#(
  parameter int unsigned CENTURY     = 20,
  parameter int unsigned RESET_YEAR  = 0,
  parameter int unsigned RESET_MONTH = 1,
  parameter int unsigned RESET_DAY   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       day_tick,
  input  logic       set_req,
  input  logic [7:0] set_year,
  input  logic [7:0] set_month,
  input  logic [7:0] set_day,
  output logic [7:0] year,
  output logic [7:0] month,
  output logic [7:0] day,
  output logic [2:0] day_of_week,
  output logic       dow_valid,
  output logic       busy,
  output logic       set_ack,
  output logic       set_err
`ifdef CAL_WEEK_TICK_EN
  , output logic     week_tick
`endif
);

  logic [7:0] yy_q, month_q, day_q;
  logic [2:0] dow_q;
  logic       dow_valid_q, pending_q, init_q, set_ack_q, set_err_q;
  logic       eng_busy, eng_done, eng_start;
  logic [2:0] eng_dow;
  logic       can_act, do_set, set_ok, do_tick, year_wrap;
  logic [7:0] cur_dim, set_dim, nx_yy, nx_month, nx_day;
  logic [2:0] dow_inc;

  always_comb begin
    cur_dim = days_in_month(month_q, is_leap(yy_q));
    set_dim = days_in_month(set_month, is_leap(set_year));
    set_ok  = (set_year <= 8'd99) && (set_month >= 8'd1) && (set_month <= 8'd12) &&
              (set_day >= 8'd1) && (set_day <= set_dim);
    can_act = !eng_busy && !init_q;
    // Skip the cycle of a set_err pulse so a requester still holding set_req is not rejected twice.
    do_set  = can_act && !pending_q && set_req && !set_err_q;
    do_tick = can_act && (pending_q || (day_tick && !do_set));

    nx_yy     = yy_q;
    nx_month  = month_q;
    nx_day    = day_q;
    year_wrap = 1'b0;
    if (day_q < cur_dim) begin
      nx_day = day_q + 8'd1;
    end else begin
      nx_day = 8'd1;
      if (month_q >= 8'd12) begin
        nx_month = 8'd1;
        if (yy_q >= 8'd99) begin
          nx_yy     = 8'd0;
          year_wrap = 1'b1;
        end else begin
          nx_yy = yy_q + 8'd1;
        end
      end else begin
        nx_month = month_q + 8'd1;
      end
    end
    dow_inc   = (dow_q == DOW_FRI) ? DOW_SAT : dow_q + 3'd1;
    eng_start = init_q || (do_set && set_ok) || (do_tick && year_wrap);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yy_q        <= 8'(RESET_YEAR);
      month_q     <= 8'(RESET_MONTH);
      day_q       <= 8'(RESET_DAY);
      dow_q       <= DOW_SAT;
      dow_valid_q <= 1'b0;
      pending_q   <= 1'b0;
      init_q      <= 1'b1;
      set_ack_q   <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      init_q    <= 1'b0;
      set_ack_q <= do_set && set_ok;
      set_err_q <= do_set && !set_ok;

      if (day_tick && !can_act)
        pending_q <= 1'b1;
      else if (do_tick)
        pending_q <= 1'b0;

      if (do_set && set_ok) begin
        yy_q    <= set_year;
        month_q <= set_month;
        day_q   <= set_day;
      end else if (do_tick) begin
        yy_q    <= nx_yy;
        month_q <= nx_month;
        day_q   <= nx_day;
      end

      if (eng_start) begin
        dow_valid_q <= 1'b0;
      end else if (eng_done) begin
        dow_q       <= eng_dow;
        dow_valid_q <= 1'b1;
      end else if (do_tick) begin
        dow_q <= dow_inc;
      end
    end
  end

  cal_dow_engine #(
    .CENTURY(CENTURY)
  ) u_engine (
    .clk  (clk),
    .rst_n(rst_n),
    .start(eng_start),
    .yy   (yy_q),
    .month(month_q),
    .day  (day_q),
    .busy (eng_busy),
    .done (eng_done),
    .dow  (eng_dow)
  );

`ifdef CAL_WEEK_TICK_EN
  logic week_tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      week_tick_q <= 1'b0;
    else
      week_tick_q <= (eng_done && (eng_dow == DOW_SUN)) ||
                     (do_tick && !year_wrap && (dow_inc == DOW_SUN));
  end

  assign week_tick = week_tick_q;
`endif

  assign year        = yy_q;
  assign month       = month_q;
  assign day         = day_q;
  assign day_of_week = dow_q;
  assign dow_valid   = dow_valid_q;
  assign busy        = eng_busy;
  assign set_ack     = set_ack_q;
  assign set_err     = set_err_q;

endmodule

// File: tb/tb_calendar_date_ctrl.sv
// Directed bench for calendar_date_ctrl: expected dates/weekdays queued at stimulus, popped when the DUT settles.
module tb_calendar_date_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       day_tick = 1'b0;
  logic       set_req = 1'b0;
  logic [7:0] set_year = 8'd0;
  logic [7:0] set_month = 8'd0;
  logic [7:0] set_day = 8'd0;
  logic [7:0] year, month, day;
  logic [2:0] day_of_week;
  logic       dow_valid, busy, set_ack, set_err;
`ifdef CAL_WEEK_TICK_EN
  logic       week_tick;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] m;
    logic [7:0] d;
    logic [2:0] w;
  } date_t;

  date_t exp_q[$];

  calendar_date_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .day_tick   (day_tick),
    .set_req    (set_req),
    .set_year   (set_year),
    .set_month  (set_month),
    .set_day    (set_day),
    .year       (year),
    .month      (month),
    .day        (day),
    .day_of_week(day_of_week),
    .dow_valid  (dow_valid),
    .busy       (busy),
    .set_ack    (set_ack),
    .set_err    (set_err)
`ifdef CAL_WEEK_TICK_EN
    , .week_tick(week_tick)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_date(input logic [7:0] y, input logic [7:0] m, input logic [7:0] d,
                             input logic [2:0] w);
    date_t e;
    e.y = y;
    e.m = m;
    e.d = d;
    e.w = w;
    exp_q.push_back(e);
  endtask

  task automatic compare_date(input string tag);
    date_t e;
    chk({tag, "_sb"}, exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_yy"}, {24'd0, year}, {24'd0, e.y});
      chk({tag, "_month"}, {24'd0, month}, {24'd0, e.m});
      chk({tag, "_day"}, {24'd0, day}, {24'd0, e.d});
      chk({tag, "_dow"}, {29'd0, day_of_week}, {29'd0, e.w});
      chk({tag, "_valid"}, {31'd0, dow_valid}, 1);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || !dow_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_settled"}, {31'd0, !busy && dow_valid}, 1);
  endtask

  task automatic do_set(input string tag, input logic [7:0] y, input logic [7:0] m,
                        input logic [7:0] d, input bit with_tick, input bit ok);
    int n = 0;
    @(negedge clk);
    set_req   = 1'b1;
    set_year  = y;
    set_month = m;
    set_day   = d;
    day_tick  = with_tick;
    @(negedge clk);
    day_tick = 1'b0;
    while (!set_ack && !set_err && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ack"}, {31'd0, set_ack}, {31'd0, ok});
    chk({tag, "_err"}, {31'd0, set_err}, {31'd0, !ok});
    if (ok) chk({tag, "_busy"}, {31'd0, busy}, 1);
    set_req = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, set_ack | set_err}, 0);
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    day_tick = 1'b1;
    @(negedge clk);
    day_tick = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_yy", {24'd0, year}, 0);
    chk("rst_month", {24'd0, month}, 1);
    chk("rst_day", {24'd0, day}, 1);
    chk("rst_dow", {29'd0, day_of_week}, 0);
    chk("rst_valid", {31'd0, dow_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ack_err", {30'd0, set_ack, set_err}, 0);
    rst_n = 1'b1;
    n = 0;
    while (!dow_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("init_latency_le16", {31'd0, n <= 16}, 1);
    expect_date(8'd0, 8'd1, 8'd1, 3'd0);
    compare_date("init");

    do_set("set_20240315", 8'd24, 8'd3, 8'd15, 1'b0, 1'b1);
    expect_date(8'd24, 8'd3, 8'd15, 3'd6);
    wait_idle("set_20240315");
    compare_date("set_20240315");

    do_set("set_20240228", 8'd24, 8'd2, 8'd28, 1'b0, 1'b1);
    expect_date(8'd24, 8'd2, 8'd28, 3'd4);
    wait_idle("set_20240228");
    compare_date("set_20240228");
    pulse_tick();
    expect_date(8'd24, 8'd2, 8'd29, 3'd5);
    chk("leap_tick_busy", {31'd0, busy}, 0);
    compare_date("tick_20240229");
    pulse_tick();
    expect_date(8'd24, 8'd3, 8'd1, 3'd6);
    compare_date("tick_20240301");

    do_set("set_20230228", 8'd23, 8'd2, 8'd28, 1'b0, 1'b1);
    expect_date(8'd23, 8'd2, 8'd28, 3'd3);
    wait_idle("set_20230228");
    compare_date("set_20230228");
    pulse_tick();
    expect_date(8'd23, 8'd3, 8'd1, 3'd4);
    compare_date("tick_20230301");

    do_set("bad_20230229", 8'd23, 8'd2, 8'd29, 1'b0, 1'b0);
    expect_date(8'd23, 8'd3, 8'd1, 3'd4);
    compare_date("bad_20230229");
    do_set("bad_month13", 8'd23, 8'd13, 8'd1, 1'b0, 1'b0);
    expect_date(8'd23, 8'd3, 8'd1, 3'd4);
    compare_date("bad_month13");
    do_set("bad_day0", 8'd23, 8'd5, 8'd0, 1'b0, 1'b0);
    expect_date(8'd23, 8'd3, 8'd1, 3'd4);
    compare_date("bad_day0");

    do_set("set_20991231", 8'd99, 8'd12, 8'd31, 1'b0, 1'b1);
    expect_date(8'd99, 8'd12, 8'd31, 3'd5);
    wait_idle("set_20991231");
    compare_date("set_20991231");
    pulse_tick();
    chk("wrap_busy", {31'd0, busy}, 1);
    chk("wrap_valid_low", {31'd0, dow_valid}, 0);
    chk("wrap_date", {8'd0, year, month, day}, {8'd0, 8'd0, 8'd1, 8'd1});
    expect_date(8'd0, 8'd1, 8'd1, 3'd0);
    wait_idle("wrap");
    compare_date("wrap");

    do_set("set_with_tick", 8'd24, 8'd3, 8'd15, 1'b1, 1'b1);
    expect_date(8'd24, 8'd3, 8'd15, 3'd6);
    wait_idle("set_with_tick");
    repeat (3) @(negedge clk);
    compare_date("set_with_tick");

    do_set("busy_tick", 8'd24, 8'd2, 8'd28, 1'b0, 1'b1);
    pulse_tick();
    expect_date(8'd24, 8'd2, 8'd29, 3'd5);
    wait_idle("busy_tick");
    repeat (3) @(negedge clk);
    compare_date("busy_tick");

    do_set("busy_two_ticks", 8'd23, 8'd2, 8'd28, 1'b0, 1'b1);
    pulse_tick();
    pulse_tick();
    expect_date(8'd23, 8'd3, 8'd1, 3'd4);
    wait_idle("busy_two_ticks");
    repeat (3) @(negedge clk);
    compare_date("busy_two_ticks");

    do_set("abort_set", 8'd24, 8'd3, 8'd15, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_date", {8'd0, year, month, day}, {8'd0, 8'd0, 8'd1, 8'd1});
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_valid", {31'd0, dow_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_date(8'd0, 8'd1, 8'd1, 3'd0);
    wait_idle("abort_recompute");
    compare_date("abort_recompute");

`ifdef CAL_WEEK_TICK_EN
    chk("week_tick_idle", {31'd0, week_tick}, 0);
    pulse_tick();
    chk("week_tick_pulse", {31'd0, week_tick}, 1);
    chk("week_tick_dow", {29'd0, day_of_week}, 1);
    @(negedge clk);
    chk("week_tick_one_cycle", {31'd0, week_tick}, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
